ysyx_22041071_div_ctrl: RTL and testbench

YSYX_22041071_DIV_CTRL -- requirements
Module: ysyx_22041071_div_ctrl

---
 rtl/ysyx_22041071_div_ctrl_pkg.sv | 39 +++
 rtl/ysyx_22041071_div_special.sv | 29 ++
 rtl/ysyx_22041071_div_ctrl.sv | 144 ++++++++++++++
 tb/tb_ysyx_22041071_div_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041071_div_ctrl_pkg.sv
// Shared op/state encodings and operand helpers for the RV64 divider controller.
package ysyx_22041071_div_ctrl_pkg;

  localparam int unsigned YSYX_22041071_XLEN = 64;

  typedef enum logic [1:0] {
    YSYX_22041071_OP_DIV  = 2'b00,
    YSYX_22041071_OP_DIVU = 2'b01,
    YSYX_22041071_OP_REM  = 2'b10,
    YSYX_22041071_OP_REMU = 2'b11
  } ysyx_22041071_div_op_e;

  typedef enum logic [1:0] {
    YSYX_22041071_S_IDLE  = 2'b00,
    YSYX_22041071_S_WAIT  = 2'b01,
    YSYX_22041071_S_RESP  = 2'b10,
    YSYX_22041071_S_DRAIN = 2'b11
  } ysyx_22041071_div_state_e;

  function automatic logic ysyx_22041071_is_signed(input ysyx_22041071_div_op_e op);
    return (op == YSYX_22041071_OP_DIV) || (op == YSYX_22041071_OP_REM);
  endfunction

  function automatic logic ysyx_22041071_is_rem(input ysyx_22041071_div_op_e op);
    return (op == YSYX_22041071_OP_REM) || (op == YSYX_22041071_OP_REMU);
  endfunction

  // *W results are the low word sign-extended to 64 bits.
  function automatic logic [63:0] ysyx_22041071_sext_w(input logic [63:0] v, input logic is_word);
    return is_word ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  // *W operands keep only the low word, extended according to signedness.
  function automatic logic [63:0] ysyx_22041071_norm_opnd(input logic [63:0] v, input logic is_word,
                                                          input logic is_signed);
    return is_word ? {{32{is_signed & v[31]}}, v[31:0]} : v;
  endfunction

endpackage

// File: rtl/ysyx_22041071_div_special.sv
// Combinational detection of divide-by-zero and signed overflow, with the architectural result.
module ysyx_22041071_div_special
  import ysyx_22041071_div_ctrl_pkg::*;
(
  input  ysyx_22041071_div_op_e             op,
  input  logic                              is_word,
  input  logic [YSYX_22041071_XLEN-1:0]     dividend,
  input  logic [YSYX_22041071_XLEN-1:0]     divisor,
  output logic                              bypass,
  output logic [YSYX_22041071_XLEN-1:0]     result
);

  logic                          div_zero;
  logic                          overflow;
  logic [YSYX_22041071_XLEN-1:0] quo;
  logic [YSYX_22041071_XLEN-1:0] rem;

  always_comb begin
    div_zero = is_word ? (divisor[31:0] == 32'd0) : (divisor == '0);
    overflow = ysyx_22041071_is_signed(op) &
               (is_word ? ((dividend[31:0] == 32'h8000_0000) && (divisor[31:0] == 32'hFFFF_FFFF))
                        : ((dividend == {1'b1, 63'd0}) && (divisor == '1)));
    quo      = div_zero ? '1 : dividend;
    rem      = div_zero ? dividend : '0;
    bypass   = div_zero | overflow;
    result   = ysyx_22041071_sext_w(ysyx_22041071_is_rem(op) ? rem : quo, is_word);
  end

endmodule

// File: rtl/ysyx_22041071_div_ctrl.sv
// Sequencing between the pipeline and the iterative divider: special-case bypass, flush/drain.
// Define YSYX_22041071_DIV_CACHE_EN to add a one-entry cache of the last divider result.
module ysyx_22041071_div_ctrl
  import ysyx_22041071_div_ctrl_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [1:0]                    op,
  input  logic                          is_word,
  input  logic [YSYX_22041071_XLEN-1:0] src1,
  input  logic [YSYX_22041071_XLEN-1:0] src2,
  input  logic                          flush,
  output logic                          res_valid,
  output logic [YSYX_22041071_XLEN-1:0] result,
  output logic                          busy,
  output logic                          div_valid,
  output logic                          div_signed,
  output logic                          divw,
  output logic                          div_flush,
  output logic [YSYX_22041071_XLEN-1:0] dividend,
  output logic [YSYX_22041071_XLEN-1:0] divisor,
  input  logic                          div_ready,
  input  logic                          out_valid,
  input  logic [YSYX_22041071_XLEN-1:0] quot,
  input  logic [YSYX_22041071_XLEN-1:0] rema
);

  ysyx_22041071_div_state_e      state, state_nxt;
  ysyx_22041071_div_op_e         op_in;
  logic                          in_signed;
  logic                          accept;
  logic                          divider_done;
  logic                          sel_rem_q;
  logic                          word_q;
  logic                          spec_hit;
  logic                          cache_hit;
  logic [YSYX_22041071_XLEN-1:0] a_in;
  logic [YSYX_22041071_XLEN-1:0] b_in;
  logic [YSYX_22041071_XLEN-1:0] spec_result;
  logic [YSYX_22041071_XLEN-1:0] cache_result;

  assign op_in     = ysyx_22041071_div_op_e'(op);
  assign in_signed = ysyx_22041071_is_signed(op_in);
  assign a_in      = ysyx_22041071_norm_opnd(src1, is_word, in_signed);
  assign b_in      = ysyx_22041071_norm_opnd(src2, is_word, in_signed);

  assign req_ready    = (state == YSYX_22041071_S_IDLE) & div_ready;
  assign accept       = req_valid & req_ready & ~flush;
  assign busy         = (state != YSYX_22041071_S_IDLE);
  // A flush landing in the response cycle kills the pulse before the pipeline sees it.
  assign res_valid    = (state == YSYX_22041071_S_RESP) & ~flush;
  assign divider_done = (state == YSYX_22041071_S_WAIT) & out_valid & ~flush;

  ysyx_22041071_div_special u_special (
    .op       (op_in),
    .is_word  (is_word),
    .dividend (a_in),
    .divisor  (b_in),
    .bypass   (spec_hit),
    .result   (spec_result)
  );

`ifdef YSYX_22041071_DIV_CACHE_EN
  logic                          c_valid;
  logic                          c_signed;
  logic                          c_word;
  logic [YSYX_22041071_XLEN-1:0] c_src1, c_src2, c_quot, c_rema;

  assign cache_hit    = c_valid & (c_src1 == a_in) & (c_src2 == b_in) &
                        (c_signed == in_signed) & (c_word == is_word);
  assign cache_result = ysyx_22041071_sext_w(ysyx_22041071_is_rem(op_in) ? c_rema : c_quot, is_word);

  // NOTE: only the valid bit needs reset; the payload is never read while c_valid is low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      c_valid <= 1'b0;
    end else if (divider_done) begin
      c_valid  <= 1'b1;
      c_src1   <= dividend;
      c_src2   <= divisor;
      c_signed <= div_signed;
      c_word   <= divw;
      c_quot   <= quot;
      c_rema   <= rema;
    end
  end
`else
  assign cache_hit    = 1'b0;
  assign cache_result = '0;
`endif

  // NOTE: defaulting state_nxt first keeps every path assigned, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      YSYX_22041071_S_IDLE: begin
        if (accept) state_nxt = (spec_hit | cache_hit) ? YSYX_22041071_S_RESP : YSYX_22041071_S_WAIT;
      end
      YSYX_22041071_S_WAIT: begin
        if (flush)          state_nxt = out_valid ? YSYX_22041071_S_IDLE : YSYX_22041071_S_DRAIN;
        else if (out_valid) state_nxt = YSYX_22041071_S_RESP;
      end
      YSYX_22041071_S_RESP:  state_nxt = YSYX_22041071_S_IDLE;
      YSYX_22041071_S_DRAIN: if (out_valid) state_nxt = YSYX_22041071_S_IDLE;
      default:               state_nxt = YSYX_22041071_S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= YSYX_22041071_S_IDLE;
      result     <= '0;
      div_valid  <= 1'b0;
      div_flush  <= 1'b0;
      div_signed <= 1'b0;
      divw       <= 1'b0;
      dividend   <= '0;
      divisor    <= '0;
      sel_rem_q  <= 1'b0;
      word_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_flush <= (state == YSYX_22041071_S_WAIT) & flush;
      if (accept) begin
        sel_rem_q  <= ysyx_22041071_is_rem(op_in);
        word_q     <= is_word;
        dividend   <= a_in;
        divisor    <= b_in;
        div_signed <= in_signed;
        divw       <= is_word;
        div_valid  <= ~(spec_hit | cache_hit);
        if (spec_hit)       result <= spec_result;
        else if (cache_hit) result <= cache_result;
      end else if ((state == YSYX_22041071_S_WAIT) && (out_valid || flush)) begin
        div_valid <= 1'b0;
      end
      if (divider_done) result <= ysyx_22041071_sext_w(sel_rem_q ? rema : quot, word_q);
    end
  end

endmodule

// File: tb/tb_ysyx_22041071_div_ctrl.sv
// Self-checking bench for ysyx_22041071_div_ctrl with a 131-cycle behavioural divider.
`timescale 1ns/1ps
module tb_ysyx_22041071_div_ctrl;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [1:0]  op = 2'b00;
  logic        is_word = 1'b0;
  logic [63:0] src1 = '0, src2 = '0;
  logic        flush = 1'b0;
  logic        res_valid, busy;
  logic [63:0] result;
  logic        div_valid, div_signed, divw, div_flush;
  logic [63:0] dividend, divisor;
  logic        div_ready = 1'b1, out_valid = 1'b0;
  logic [63:0] quot = '0, rema = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_22041071_div_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .op(op),
    .is_word(is_word), .src1(src1), .src2(src2), .flush(flush), .res_valid(res_valid),
    .result(result), .busy(busy), .div_valid(div_valid), .div_signed(div_signed), .divw(divw),
    .div_flush(div_flush), .dividend(dividend), .divisor(divisor), .div_ready(div_ready),
    .out_valid(out_valid), .quot(quot), .rema(rema)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Architectural RISC-V division; word results zero-extended here.
  function automatic logic [63:0] tb_qr(input bit sgn, input bit w, input logic [63:0] a,
                                        input logic [63:0] b, input bit rem);
    logic [31:0] a32, b32, q32, r32;
    logic [63:0] q, r;
    a32 = a[31:0];
    b32 = b[31:0];
    q32 = '0; r32 = '0;
    if (w) begin
      if (b32 == 32'd0) begin q32 = '1; r32 = a32; end
      else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = '0; end
      else if (sgn) begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
      else begin q32 = a32 / b32; r32 = a32 % b32; end
      q = {32'd0, q32};
      r = {32'd0, r32};
    end else begin
      if (b == 64'd0) begin q = '1; r = a; end
      else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = '0; end
      else if (sgn) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
      else begin q = a / b; r = a % b; end
    end
    return rem ? r : q;
  endfunction

  function automatic logic [63:0] ref_result(input logic [1:0] o, input bit w, input logic [63:0] a,
                                             input logic [63:0] b);
    logic [63:0] v;
    v = tb_qr(!o[0], w, a, b, o[1]);
    return w ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  function automatic bit tb_special(input logic [1:0] o, input bit w, input logic [63:0] a,
                                    input logic [63:0] b);
    bit sgn;
    sgn = !o[0];
    if (w) return (b[31:0] == 32'd0) || (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 64'd0) || (sgn && a == 64'h8000_0000_0000_0000 && b == '1);
  endfunction

  // One-entry result cache as seen from outside: keyed on effective operands, signedness, width.
  bit          c_valid = 0, c_sgn = 0, c_w = 0;
  logic [63:0] c_a = '0, c_b = '0;

  function automatic logic [63:0] eff(input logic [63:0] v, input bit w);
    return w ? {32'd0, v[31:0]} : v;
  endfunction

  function automatic bit cache_hit(input bit sgn, input bit w, input logic [63:0] a, input logic [63:0] b);
`ifdef YSYX_22041071_DIV_CACHE_EN
    return c_valid && c_sgn == sgn && c_w == w && c_a == eff(a, w) && c_b == eff(b, w);
`else
    return 1'b0;
`endif
  endfunction

  // Divider model: out_valid 129 cycles after div_valid is first seen, then idle again.
  logic dm_rst;
  bit   dm_active = 0;
  int   dm_cnt = 0;
  always @(posedge clk) begin
    dm_rst = reset;
    #2;
    if (!dm_rst) begin
      dm_active = 0; out_valid = 1'b0; div_ready = 1'b1;
    end else if (out_valid) begin
      out_valid = 1'b0; dm_active = 0; div_ready = 1'b1;
    end else if (dm_active) begin
      dm_cnt++;
      if (dm_cnt == 129) out_valid = 1'b1;
    end else if (div_valid) begin
      dm_active = 1; dm_cnt = 0; div_ready = 1'b0;
      quot = tb_qr(div_signed, divw, dividend, divisor, 1'b0);
      rema = tb_qr(div_signed, divw, dividend, divisor, 1'b1);
    end
  end

  // Offer an op from the posedge+1 phase; returns at posedge+1 of the cycle after acceptance.
  task automatic drive_op(input logic [1:0] o, input bit w, input logic [63:0] a, input logic [63:0] b,
                          output bit ok);
    req_valid = 1'b1; op = o; is_word = w; src1 = a; src2 = b;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input bit w, input logic [63:0] a,
                        input logic [63:0] b);
    logic [63:0] exp;
    bit spec, hit, ok, seen, dv_seen, sgn;
    int lat;
    sgn  = !o[0];
    exp  = ref_result(o, w, a, b);
    spec = tb_special(o, w, a, b);
    hit  = !spec && cache_hit(sgn, w, a, b);
    drive_op(o, w, a, b, ok);
    check({tag, "_accept"}, 64'(ok), 64'd1);
    seen = 0; dv_seen = 0; lat = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (div_valid) begin
        dv_seen = 1;
        check({tag, "_opnd"}, {dividend[31:0], divisor[31:0]}, {a[31:0], b[31:0]});
        if (!w) check({tag, "_opnd_hi"}, {dividend[63:32], divisor[63:32]}, {a[63:32], b[63:32]});
        check({tag, "_ctl"}, {62'd0, div_signed, divw}, {62'd0, sgn, w});
      end
      if (res_valid) begin seen = 1; lat = i; break; end
    end
    check({tag, "_seen"}, 64'(seen), 64'd1);
    check({tag, "_result"}, result, exp);
    check({tag, "_latency"}, 64'(lat), (spec || hit) ? 64'd1 : 64'd131);
    check({tag, "_div_used"}, 64'(dv_seen), (spec || hit) ? 64'd0 : 64'd1);
    check({tag, "_dv_fall"}, 64'(div_valid), 64'd0);
    @(negedge clk);
    check({tag, "_one_pulse"}, {62'd0, res_valid, busy}, 64'd0);
    @(posedge clk); #1;
    if (!spec && !hit) begin
      c_valid = 1; c_sgn = sgn; c_w = w; c_a = eff(a, w); c_b = eff(b, w);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, ov_seen, no_res, drained;
    logic [63:0] a, b, pa, pb;
    logic [1:0] o;
    bit w;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", {59'd0, res_valid, div_valid, div_flush, busy, req_ready}, 64'd1);
    check("rst_result", result, 64'd0);
    check("rst_opnd", dividend | divisor, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    run_op("div_neg7_2", OP_DIV, 0, -64'sd7, 64'd2);
    run_op("remuw_zero", OP_REMU, 1, 64'h0000_0000_FFFF_FFFF, 64'd0);
    run_op("divw_ovf", OP_DIV, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF);
    run_op("div_100_7", OP_DIV, 0, 64'd100, 64'd7);
    run_op("rem_100_7", OP_REM, 0, 64'd100, 64'd7);

    // Flush while the divider is working; the late out_valid must be drained silently.
    drive_op(OP_DIVU, 0, 64'd100, 64'd7, ok);
    check("flw_accept", 64'(ok), 64'd1);
    repeat (20) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flw_dflush", {61'd0, div_flush, div_valid, busy, res_valid}, 64'b1010);
    @(negedge clk);
    check("flw_dflush_once", 64'(div_flush), 64'd0);
    ov_seen = 0; no_res = 1; drained = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (res_valid) no_res = 0;
      if (!busy) begin drained = 1; break; end
      if (out_valid) ov_seen = 1;
    end
    check("flw_drained", 64'(drained), 64'd1);
    check("flw_ov_before_idle", 64'(ov_seen), 64'd1);
    check("flw_no_res", 64'(no_res), 64'd1);
    check("flw_ready_after", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    run_op("flw_redo", OP_DIVU, 0, 64'd100, 64'd7);

    // Flush in the same cycle as out_valid: straight back to IDLE, no response.
    drive_op(OP_DIV, 0, 64'd1000, 64'd9, ok);
    check("flov_accept", 64'(ok), 64'd1);
    repeat (129) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flov_nores0", 64'(res_valid), 64'd0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flov_idle", {61'd0, res_valid, busy, div_valid}, 64'd0);
    @(posedge clk); #1;
    run_op("flov_redo", OP_DIV, 0, 64'd1000, 64'd9);

    // Flush during RESP of a bypassed op.
    drive_op(OP_DIV, 0, 64'd5, 64'd0, ok);
    check("flr_accept", 64'(ok), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    check("flr_nores", 64'(res_valid), 64'd0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flr_idle", {62'd0, res_valid, busy}, 64'd0);
    @(posedge clk); #1;

    pa = 64'd77; pb = 64'd5;
    for (int n = 0; n < 20; n++) begin
      o = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      case ($urandom_range(0, 9))
        0: b = w ? {$urandom, 32'd0} : 64'd0;
        1: begin
          a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = w ? {$urandom, 32'hFFFF_FFFF} : '1;
        end
        2, 3: begin a = pa; b = pb; end
        default: ;
      endcase
      run_op($sformatf("rnd%0d", n), o, w, a, b);
      pa = a; pb = b;
    end

    // Reset in the middle of WAIT abandons the op and clears the cache.
    drive_op(OP_DIV, 0, 64'd50, 64'd3, ok);
    check("rw_accept", 64'(ok), 64'd1);
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    c_valid = 0;
    @(negedge clk);
    check("rw_ctl", {59'd0, res_valid, div_valid, div_flush, busy, req_ready}, 64'd1);
    check("rw_regs", result | dividend | divisor, 64'd0);
    @(posedge clk); #1;
    run_op("rw_div_10_3", OP_DIV, 0, 64'd10, 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
